// File: rtl/if_id_realign_buffer_if.sv
// Fetch-to-decode handshake bundle for the IF/ID realignment buffer.
// master: fetch/hazard side driving groups in; slave: the buffer.
interface if_id_realign_buffer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]       fetch_valid_cnt;
  logic [2:0][31:0] fetch_pc;
  logic [2:0][31:0] fetch_inst;
  logic             fetch_ready;
  logic [1:0]       rollback;
  logic [2:0]       id_valid;
  logic [2:0][31:0] id_pc;
  logic [2:0][31:0] id_inst;
  logic [CW-1:0]    count;
  logic [15:0]      stall_cycles;

  modport master (
    output fetch_valid_cnt, fetch_pc, fetch_inst, rollback,
    input  fetch_ready, id_valid, id_pc, id_inst, count, stall_cycles
  );

  modport slave (
    input  fetch_valid_cnt, fetch_pc, fetch_inst, rollback,
    output fetch_ready, id_valid, id_pc, id_inst, count, stall_cycles
  );
endinterface

// File: rtl/if_id_realign_buffer.sv
// Circular buffer between fetch and decode: presents the oldest three entries
// as an ID group and re-presents whatever the hazard unit rolls back.
module if_id_realign_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic                   clock,
  input logic                   reset,
  input logic                   flush,
  if_id_realign_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     fetch_ready_q, fetch_ready_d;
  logic [15:0]              stall_q, stall_d;
  logic [DEPTH-1:0][31:0]   pc_q, pc_d, inst_q, inst_d;

  logic [2:0]               id_valid_c;
  logic [2:0][31:0]         id_pc_c, id_inst_c;
  logic [1:0]               avail, pop_n, push_n;

  // ID group: oldest min(count,3) entries, invalid ways show a NOP at PC 0
  always_comb begin
    id_valid_c = '0;
    id_pc_c    = '0;
    id_inst_c  = {3{NOP_INST}};
    for (int i = 0; i < 3; i++) begin
      if (CW'(i) < count_q) begin
        id_valid_c[i] = 1'b1;
        id_pc_c[i]    = pc_q[head_q + AW'(i)];
        id_inst_c[i]  = inst_q[head_q + AW'(i)];
      end
    end
  end

  always_comb begin
    avail  = 2'd3 - bus.rollback;
    pop_n  = (count_q < CW'(avail)) ? count_q[1:0] : avail;
    push_n = fetch_ready_q ? bus.fetch_valid_cnt : 2'd0;

    pc_d   = pc_q;
    inst_d = inst_q;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < push_n) begin
        pc_d[tail_q + AW'(i)]   = bus.fetch_pc[i];
        inst_d[tail_q + AW'(i)] = bus.fetch_inst[i];
      end
    end

    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + AW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);

    stall_d = stall_q;
    if ((bus.rollback != 2'd0) && (|id_valid_c) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;

    // Redirect squashes everything, including this cycle's push and pop
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = pc_q;
      inst_d  = inst_q;
      stall_d = stall_q;
    end

    // Registered so fetch_ready has no path from fetch or rollback inputs
    fetch_ready_d = (count_d <= CW'(DEPTH - 3));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_ready_q <= 1'b1;
      stall_q       <= '0;
      pc_q          <= '0;
      inst_q        <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_ready_q <= fetch_ready_d;
      stall_q       <= stall_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
    end
  end

  assign bus.fetch_ready  = fetch_ready_q;
  assign bus.id_valid     = id_valid_c;
  assign bus.id_pc        = id_pc_c;
  assign bus.id_inst      = id_inst_c;
  assign bus.count        = count_q;
  assign bus.stall_cycles = stall_q;
endmodule
